if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction cache.
- Owns the program counter and drives it to the cache as `if_pc`, with one PC value per instruction word.
- Consumes the cache's hit flag and instruction word and pushes each fetched instruction into a 2-entry queue feeding the decode stage.
- Holds the PC stable for the whole cache line fill and defers branch/jump redirects that arrive mid-fill.

Parameters:
- WORD_SIZE, 16, width of PC and instruction.
- RESET_PC, 16'h0000, PC value loaded on reset.
- QUEUE_DEPTH, 2, instruction queue entries (fixed at 2; the count register is 2 bits).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-high reset: the block resets when reset_n = 1 (name kept for codebase consistency).
- if_pc  output  WORD_SIZE  PC presented to the instruction cache.
- ic_hit  input  1  cache hit flag; valid instruction word this cycle.
- ic_data  input  WORD_SIZE  instruction word from the cache.
- redirect_valid  input  1  single-cycle branch/jump redirect from the execute stage.
- redirect_pc  input  WORD_SIZE  redirect target.
- id_ready  input  1  decode stage accepts the head entry this cycle.
- id_valid  output  1  queue head is valid.
- id_inst  output  WORD_SIZE  head instruction.
- id_pc  output  WORD_SIZE  PC of the head instruction.

Behaviour:
- Reset (asynchronous, reset_n = 1):
  - pc <= RESET_PC.
  - Queue count = 0; id_valid = 0; id_inst = 0; id_pc = 0.
  - State = RUN; pending_pc = 0.
- if_pc = pc, combinational from the register.
- Dequeue: occurs when id_valid && id_ready. The head is combinational from entry 0; entry 1 shifts into entry 0.
- Enqueue condition, state RUN: ic_hit && !redirect_valid && (count < 2 || dequeue). On enqueue:
  - {ic_data, pc} is written at the tail;
  - pc <= pc + 1, wrapping modulo 2^16 (16'hFFFF -> 16'h0000).
- Simultaneous enqueue and dequeue: count is unchanged; the new word lands behind the shifted head.
- Full queue with no dequeue: pc is held and ic_hit is ignored. The cache keeps hitting the same address, which is harmless.
- States:
  - RUN:
    - ic_hit = 0 -> MISS; pc frozen.
    - redirect_valid -> flush the queue (count <= 0, same cycle, overriding any enqueue or dequeue); pc <= redirect_pc; stay in RUN.
  - MISS:
    - pc frozen, because the cache refills from the live PC and any change corrupts the line.
    - ic_hit = 1 -> RUN, and the word is enqueued under the RUN rules in that same cycle.
    - redirect_valid -> flush the queue; pending_pc <= redirect_pc; -> MISS_REDIR.
  - MISS_REDIR:
    - pc frozen; the queue stays empty.
    - A further redirect_valid overwrites pending_pc; the last redirect wins.
    - ic_hit = 1 -> discard the word; pc <= pending_pc; -> RUN.
- Redirect and ic_hit in the same RUN cycle: the redirect wins and the hit word is discarded.
- A dequeue in the redirect cycle is still delivered to decode: the head was visible before the edge. The flush applies after the edge.
- id_inst and id_pc are 0 whenever id_valid = 0.
- Reset mid-fill: the state returns to RUN and pc to RESET_PC asynchronously. Cache refill sequencing is not this block's concern.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- When defined, two extra output ports are added:
  - perf_miss_cycles[31:0]: increments every cycle the state is MISS or MISS_REDIR.
  - perf_fetched[31:0]: increments on every enqueue.
  - Both are cleared by reset and saturate at 32'hFFFFFFFF.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package / opcodes include holds:
  - WORD_SIZE;
  - the state encoding constants FETCH_RUN = 2'd0, FETCH_MISS = 2'd1, FETCH_MISS_REDIR = 2'd2;
  - RESET_PC.
- One natural sub-module: fetch_queue, a 2-entry shift FIFO with ports enq, deq, flush, din, dout, count. The FSM and PC logic stay in the top level.

Test Plan:
1. Reset, ic_hit = 1 constant, ic_data = 16'h1000 + if_pc, id_ready = 1 -> id_valid on cycle 1 with id_pc 0, 1, 2, 3 on consecutive cycles and id_inst = 16'h1000 + id_pc.
2. ic_hit = 0 for 6 cycles at pc = 16'h0004 -> if_pc holds 16'h0004 throughout; 16'h0004 is enqueued on the cycle ic_hit returns; state is back in RUN.
3. id_ready = 0 with hits -> exactly 2 entries (pc 0, 1) queued, if_pc holds 16'h0002. Raise id_ready -> order 0, 1, 2 with no loss or duplication.
4. redirect_valid with redirect_pc = 16'h0040 on cycle 3 of a miss at 16'h0008 -> if_pc holds 16'h0008 until the hit; the hit word is discarded; the next if_pc is 16'h0040; the first id_pc after the redirect is 16'h0040.
5. Redirect with a full queue and ic_hit = 1 in the same cycle -> count 0 on the next cycle, pc = target, the hit word is not enqueued.
6. pc = 16'hFFFF with a hit -> next if_pc is 16'h0000. With IF_FETCH_PERF_EN defined, a 5-cycle miss gives perf_miss_cycles = 5.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The optional performance counters are enabled by defining IF_FETCH_PERF_EN.
package if_fetch_unit_pkg;

    localparam int WORD_SIZE   = 16;
    localparam int QUEUE_DEPTH = 2;

    typedef logic [WORD_SIZE-1:0] word_t;

    localparam word_t RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        FETCH_RUN        = 2'd0,
        FETCH_MISS       = 2'd1,
        FETCH_MISS_REDIR = 2'd2
    } fetch_state_e;

    typedef struct packed {
        word_t inst;
        word_t pc;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Cache-side and decode-side signals of the fetch stage, grouped as one bundle.
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    word_t if_pc;
    logic  ic_hit;
    word_t ic_data;
    logic  redirect_valid;
    word_t redirect_pc;
    logic  id_ready;
    logic  id_valid;
    word_t id_inst;
    word_t id_pc;

    modport master (
        output if_pc, id_valid, id_inst, id_pc,
        input  ic_hit, ic_data, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  if_pc, id_valid, id_inst, id_pc,
        output ic_hit, ic_data, redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/if_fetch_unit_fetch_queue.sv
// Two-entry shift FIFO between fetch and decode; the head is always entry 0.
module fetch_queue
    import if_fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enq,
    input  logic         deq,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic [1:0]   count
);

    fetch_entry_t entry [QUEUE_DEPTH];

    // NOTE: with only two entries the storage is reset too, so no X ever reaches the head mux.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            count    <= 2'd0;
            entry[0] <= '0;
            entry[1] <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments let entry[0] take entry[1]'s pre-edge value.
            case ({enq, deq})
                2'b10: begin
                    entry[count[0]] <= din;
                    count           <= count + 2'd1;
                end
                2'b01: begin
                    entry[0] <= entry[1];
                    count    <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        entry[0] <= entry[1];
                        entry[1] <= din;
                    end else begin
                        entry[0] <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout = (count != 2'd0) ? entry[0] : '0;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, tracks cache misses, defers mid-fill redirects.
// Define IF_FETCH_PERF_EN to add the perf_miss_cycles / perf_fetched counters.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    if_fetch_unit_if.master       bus
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]           perf_miss_cycles,
    output logic [31:0]           perf_fetched
`endif
);

    fetch_state_e state, state_next;
    word_t        pc, pc_next;
    word_t        pending_pc, pending_next;
    logic [1:0]   count;
    logic         enq, deq, flush, room;
    fetch_entry_t head;

    assign deq  = bus.id_valid && bus.id_ready;
    assign room = (count < 2'd2) || deq;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) state <= FETCH_RUN;
        else         state <= state_next;
    end

    // A hit that ends a plain miss is handled exactly like a RUN cycle, redirect included.
    always_comb begin
        state_next = state;
        case (state)
            FETCH_RUN: begin
                if (!bus.redirect_valid && !bus.ic_hit) state_next = FETCH_MISS;
            end
            FETCH_MISS: begin
                if (bus.ic_hit)              state_next = FETCH_RUN;
                else if (bus.redirect_valid) state_next = FETCH_MISS_REDIR;
            end
            FETCH_MISS_REDIR: begin
                if (bus.ic_hit) state_next = FETCH_RUN;
            end
            default: state_next = FETCH_RUN;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        enq          = 1'b0;
        flush        = 1'b0;
        pc_next      = pc;
        pending_next = pending_pc;
        case (state)
            FETCH_RUN, FETCH_MISS: begin
                if (bus.redirect_valid) begin
                    flush = 1'b1;
                    if (state == FETCH_RUN || bus.ic_hit) pc_next      = bus.redirect_pc;
                    else                                  pending_next = bus.redirect_pc;
                end else if (bus.ic_hit && room) begin
                    enq     = 1'b1;
                    pc_next = pc + word_t'(1);
                end
            end
            FETCH_MISS_REDIR: begin
                flush = bus.redirect_valid;
                if (bus.redirect_valid) pending_next = bus.redirect_pc;
                if (bus.ic_hit)
                    pc_next = bus.redirect_valid ? bus.redirect_pc : pending_pc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            pc         <= RESET_PC;
            pending_pc <= '0;
        end else begin
            pc         <= pc_next;
            pending_pc <= pending_next;
        end
    end

    fetch_queue u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .enq     (enq),
        .deq     (deq),
        .flush   (flush),
        .din     ('{inst: bus.ic_data, pc: pc}),
        .dout    (head),
        .count   (count)
    );

    assign bus.if_pc    = pc;
    assign bus.id_valid = (count != 2'd0);
    assign bus.id_inst  = head.inst;
    assign bus.id_pc    = head.pc;

`ifdef IF_FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            perf_miss_cycles <= '0;
            perf_fetched     <= '0;
        end else begin
            if (state != FETCH_RUN && perf_miss_cycles != '1)
                perf_miss_cycles <= perf_miss_cycles + 32'd1;
            if (enq && perf_fetched != '1)
                perf_fetched <= perf_fetched + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a randomized run
// compared cycle by cycle against a queue-based reference model.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    typedef enum int {M_RUN, M_MISS, M_WAIT} m_state_e;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    if_fetch_unit_if bus ();

`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_miss_cycles, perf_fetched;
    int unsigned m_perf_miss, m_perf_fetch;
`endif

    if_fetch_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_miss_cycles (perf_miss_cycles),
        .perf_fetched     (perf_fetched)
`endif
    );

    always #5 clk = ~clk;

    fetch_entry_t m_q[$];
    word_t        m_pc, m_pend;
    m_state_e     m_state;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc    = RESET_PC;
        m_pend  = '0;
        m_state = M_RUN;
`ifdef IF_FETCH_PERF_EN
        m_perf_miss  = 0;
        m_perf_fetch = 0;
`endif
    endtask

    // Entered and left at a falling edge; reset is raised without a clock edge.
    task automatic do_reset();
        reset_n = 1'b1;
        #2;
        check("rst_if_pc",    bus.if_pc,    RESET_PC);
        check("rst_id_valid", bus.id_valid, 0);
        check("rst_id_inst",  bus.id_inst,  0);
        check("rst_id_pc",    bus.id_pc,    0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b0;
    endtask

    // One clock: drive inputs, compare outputs with the model, advance the model past the edge.
    task automatic cycle(input bit hit, input bit redir, input word_t rpc,
                         input bit ready, input word_t salt);
        fetch_entry_t head;
        word_t        data;
        bit           deq, room, took;
        data               = (16'h1000 + m_pc) ^ salt;
        bus.ic_hit         = hit;
        bus.ic_data        = data;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.id_ready       = ready;
        #1;
        head = '0;
        if (m_q.size() > 0) head = m_q[0];
        check("if_pc",    bus.if_pc,    m_pc);
        check("id_valid", bus.id_valid, m_q.size() > 0);
        check("id_inst",  bus.id_inst,  head.inst);
        check("id_pc",    bus.id_pc,    head.pc);
`ifdef IF_FETCH_PERF_EN
        check("perf_miss",  perf_miss_cycles, m_perf_miss);
        check("perf_fetch", perf_fetched,     m_perf_fetch);
`endif
        deq  = (m_q.size() > 0) && ready;
        room = (m_q.size() < 2) || deq;
        took = 1'b0;
        @(posedge clk);
`ifdef IF_FETCH_PERF_EN
        if (m_state != M_RUN) m_perf_miss++;
`endif
        if (deq) void'(m_q.pop_front());
        if (m_state == M_WAIT) begin
            m_q.delete();
            if (redir) m_pend = rpc;
            if (hit) begin
                m_pc    = m_pend;
                m_state = M_RUN;
            end
        end else if (redir) begin
            m_q.delete();
            if (m_state == M_RUN || hit) begin
                m_pc    = rpc;
                m_state = M_RUN;
            end else begin
                m_pend  = rpc;
                m_state = M_WAIT;
            end
        end else if (hit) begin
            if (room) begin
                m_q.push_back('{inst: data, pc: m_pc});
                m_pc = m_pc + 16'd1;
                took = 1'b1;
            end
            m_state = M_RUN;
        end else begin
            m_state = M_MISS;
        end
`ifdef IF_FETCH_PERF_EN
        if (took) m_perf_fetch++;
`else
        if (took) begin end
`endif
        @(negedge clk);
    endtask

    initial begin
        bus.ic_hit = 1'b0;
        bus.ic_data = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.id_ready = 1'b0;
        @(negedge clk);

        // Streaming hits: id_pc 0,1,2 on consecutive cycles from cycle 1.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i >= 1) check("t1_stream_pc", bus.id_pc, i - 1);
            cycle(1, 0, '0, 1, '0);
        end

        // Six-cycle miss at 0x0004: PC held, then 0x0004 enqueued and RUN resumes.
        for (int i = 0; i < 6; i++) begin
            check("t2_hold", bus.if_pc, 16'h0004);
            cycle(0, 0, '0, 1, '0);
        end
        cycle(1, 0, '0, 1, '0);
        check("t2_refill_pc", bus.id_pc, 16'h0004);
        cycle(1, 0, '0, 1, '0);
        check("t2_run_again", bus.if_pc, 16'h0006);

        // Decode stalled: two entries held, PC stuck at 2; then drained in order.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 0, '0, 0, '0);
        check("t3_full_pc", bus.if_pc, 16'h0002);
        check("t3_head",    bus.id_pc, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            check("t3_order", bus.id_pc, i);
            cycle(1, 0, '0, 1, '0);
        end

        // Redirect on the third cycle of a miss at 0x0008 is deferred until the hit.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 0, '0, 1, '0);
        cycle(0, 0, '0, 1, '0);
        cycle(0, 0, '0, 1, '0);
        cycle(0, 1, 16'h0040, 1, '0);
        for (int i = 0; i < 2; i++) begin
            check("t4_hold", bus.if_pc, 16'h0008);
            cycle(0, 0, '0, 1, '0);
        end
        cycle(1, 0, '0, 1, '0);
        check("t4_target", bus.if_pc, 16'h0040);
        check("t4_discard", bus.id_valid, 0);
        cycle(1, 0, '0, 1, '0);
        check("t4_first_pc", bus.id_pc, 16'h0040);

        // Redirect with a full queue and a hit in the same cycle.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, '0, 0, '0);
        cycle(1, 1, 16'h1234, 0, '0);
        check("t5_flushed", bus.id_valid, 0);
        check("t5_target",  bus.if_pc,    16'h1234);
        cycle(1, 0, '0, 1, '0);

        // PC wraps from 0xFFFF to 0x0000.
        cycle(0, 1, 16'hFFFF, 1, '0);
        cycle(1, 0, '0, 1, '0);
        check("t6_wrap", bus.if_pc, 16'h0000);
        check("t6_wrap_head", bus.id_pc, 16'hFFFF);

`ifdef IF_FETCH_PERF_EN
        do_reset();
        for (int i = 0; i < 5; i++) cycle(0, 0, '0, 1, '0);
        cycle(1, 0, '0, 1, '0);
        check("t6_perf_miss", perf_miss_cycles, 5);
`endif

        // Randomized traffic against the reference model, with a mid-run reset.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                  word_t'($urandom), $urandom_range(0, 9) < 7, word_t'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
